// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side signal bundle for the FIFO write arbiter
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        fifo_full;
    logic                        fifo_almostfull;
    logic                        fifo_wr_en;
    logic [DATA_WIDTH-1:0]       fifo_data_in;
    logic [OW-1:0]               owner;
    logic                        busy;

    modport master (
        output req, req_data, fifo_full, fifo_almostfull,
        input  gnt, fifo_wr_en, fifo_data_in, owner, busy
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull,
        output gnt, fifo_wr_en, fifo_data_in, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 5;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [OW-1:0]          rr_ptr;
    logic [OW-1:0]          owner_q;
    logic [CW-1:0]          cnt;
    logic                   wr_en_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic                   space_ok;
    logic                   found;
    logic [OW-1:0]          pick;
    logic [OW-1:0]          cand;
    int                     idx_i;
    logic [N_REQ-1:0]       gnt_c;
    logic                   xfer;
    logic [OW-1:0]          xidx;
    logic [DATA_WIDTH-1:0]  xword;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] v);
        if (v == OW'(N_REQ - 1))
            return '0;
        return v + OW'(1);
    endfunction

    // A write already in flight consumes the last free slot, so almostfull only blocks then.
    assign space_ok = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx_i = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_i = int'(rr_ptr) + k;
            if (idx_i >= N_REQ)
                idx_i = idx_i - N_REQ;
            cand = OW'(idx_i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (!rst) begin
            if (state == IDLE) begin
                if (space_ok && found)
                    gnt_c[pick] = 1'b1;
            end else begin
                gnt_c[owner_q] = space_ok;
            end
        end
    end

    assign xfer = |(bus.req & gnt_c);
    assign xidx = (state == IDLE) ? pick : owner_q;

    always_comb begin
        xword = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (xidx == OW'(k))
                xword = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
            cnt     <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer)
                data_q <= xword;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr <= next_idx(pick);
                        end else begin
                            state   <= BURST;
                            owner_q <= pick;
                            cnt     <= CW'(1);
                        end
                    end
                end
                BURST: begin
                    // Owner withdrawing costs one idle cycle before the next arbitration.
                    if (!bus.req[owner_q]) begin
                        state  <= IDLE;
                        rr_ptr <= next_idx(owner_q);
                        cnt    <= '0;
                    end else if (xfer) begin
                        if (cnt == CW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= next_idx(owner_q);
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state == BURST) && !rst;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int FDEPTH = 8;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] word [N];
    bit            fifo_mode = 0;
    int            fcount = 0;

    logic [N-1:0]  ghist [$];
    logic          bhist [$];
    logic          whist [$];
    logic [DW-1:0] wlog  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pack_words();
        for (int i = 0; i < N; i++)
            bus.req_data[i*DW +: DW] = word[i];
    endtask

    task automatic clear_hist();
        ghist.delete();
        bhist.delete();
        whist.delete();
        wlog.delete();
    endtask

    // One clock cycle of directed stimulus; called just after a rising edge.
    task automatic step(input logic [N-1:0] r, input logic rs, input logic f, input logic a);
        logic [N-1:0] xf;
        bus.req = r;
        rst     = rs;
        if (!fifo_mode) begin
            bus.fifo_full       = f;
            bus.fifo_almostfull = a;
        end
        @(negedge clk);
        ghist.push_back(bus.gnt);
        bhist.push_back(bus.busy);
        whist.push_back(bus.fifo_wr_en);
        if (bus.fifo_wr_en)
            wlog.push_back(bus.fifo_data_in);
        xf = bus.req & bus.gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (xf[i] && !rst)
                word[i] = word[i] + 16'd1;
        pack_words();
    endtask

    task automatic do_reset();
        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
    endtask

    // Behavioural model: who may write this cycle, and what the FIFO must see one cycle later.
    logic          m_wr_en;
    logic [DW-1:0] m_data;
    int            m_owner;
    int            m_beats;
    int            m_next;
    bit            armed = 0;
    logic [DW-1:0] sb [$];

    initial begin : model
        logic [N-1:0]  eg;
        logic          space;
        logic          t;
        int            ti;
        int            ii;
        logic [DW-1:0] tw;
        logic          s_wr;
        logic          r_s;
        bit            pop;
        logic [DW-1:0] front;
        m_wr_en = 1'b0;
        m_data  = '0;
        m_owner = -1;
        m_beats = 0;
        m_next  = 0;
        forever begin
            @(negedge clk);
            space = !bus.fifo_full && !(bus.fifo_almostfull && m_wr_en);
            eg = '0;
            if (!rst) begin
                if (m_owner < 0) begin
                    if (space)
                        for (int k = 0; k < N; k++) begin
                            ii = (m_next + k) % N;
                            if (eg == '0 && bus.req[ii])
                                eg[ii] = 1'b1;
                        end
                end else begin
                    eg[m_owner] = space;
                end
            end
            if (armed) begin
                check("gnt", 32'(bus.gnt), 32'(eg));
                check("wr_en", 32'(bus.fifo_wr_en), 32'(m_wr_en));
                check("data_in", 32'(bus.fifo_data_in), 32'(m_data));
                check("busy", 32'(bus.busy), 32'(m_owner >= 0 && !rst));
                if (m_owner >= 0 && !rst)
                    check("owner", 32'(bus.owner), 32'(m_owner));
                if (bus.fifo_wr_en) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 32'(sb.size()), 32'd1);
                    end else begin
                        front = sb.pop_front();
                        check("sb_stream", 32'(bus.fifo_data_in), 32'(front));
                    end
                end
            end
            t  = 1'b0;
            ti = 0;
            for (int i = 0; i < N; i++)
                if (bus.req[i] && eg[i]) begin
                    t  = 1'b1;
                    ti = i;
                end
            tw   = word[ti];
            s_wr = bus.fifo_wr_en;
            r_s  = rst;
            pop  = fifo_mode && ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (r_s) begin
                m_wr_en = 1'b0;
                m_data  = '0;
                m_owner = -1;
                m_beats = 0;
                m_next  = 0;
                armed   = 1;
                sb.delete();
            end else begin
                m_wr_en = t;
                if (t) begin
                    m_data = tw;
                    sb.push_back(tw);
                end
                if (m_owner < 0) begin
                    if (t) begin
                        if (MB == 1) begin
                            m_next = (ti + 1) % N;
                        end else begin
                            m_owner = ti;
                            m_beats = 1;
                        end
                    end
                end else if (!bus.req[m_owner]) begin
                    m_next  = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (t) begin
                    m_beats++;
                    if (m_beats == MB) begin
                        m_next  = (m_owner + 1) % N;
                        m_owner = -1;
                    end
                end
            end
            if (fifo_mode) begin
                if (s_wr) begin
                    if (fcount >= FDEPTH)
                        check("no_overflow", 32'(fcount), 32'(FDEPTH - 1));
                    else
                        fcount++;
                end
                if (pop && fcount > 0)
                    fcount--;
                #1;
                bus.fifo_full       = (fcount == FDEPTH);
                bus.fifo_almostfull = (fcount == FDEPTH - 1);
            end
        end
    end

    logic [15:0] exp2 [20];

    initial begin : stim
        logic [9:0] wv;
        logic [8:0] bv;
        logic [5:0] w4;
        rst = 1'b1;
        bus.req = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_almostfull = 1'b0;
        for (int i = 0; i < N; i++) word[i] = '0;
        pack_words();
        @(posedge clk);
        #1;

        // Single requester, 8 beats across two bursts
        word[0] = 16'hA000;
        pack_words();
        do_reset();
        check("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("reset_data", 32'(bus.fifo_data_in), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        clear_hist();
        repeat (8) step(4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p1_count", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < 8 && k < wlog.size(); k++)
            check("p1_word", 32'(wlog[k]), 32'(16'hA000 + k));
        wv = '0;
        for (int k = 0; k < 10; k++) wv = {wv[8:0], whist[k]};
        check("p1_wr_en_run", 32'(wv), 32'b0111111110);
        bv = '0;
        for (int k = 0; k < 9; k++) bv = {bv[7:0], bhist[k]};
        check("p1_busy_gap", 32'(bv), 32'b011101110);

        // All four requesting: round robin in bursts of four
        for (int i = 0; i < N; i++) word[i] = 16'(16'h1000 * (i + 1));
        pack_words();
        exp2 = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                 16'h2000, 16'h2001, 16'h2002, 16'h2003,
                 16'h3000, 16'h3001, 16'h3002, 16'h3003,
                 16'h4000, 16'h4001, 16'h4002, 16'h4003,
                 16'h1004, 16'h1005, 16'h1006, 16'h1007};
        do_reset();
        clear_hist();
        repeat (20) step(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p2_count", 32'(wlog.size()), 32'd20);
        for (int k = 0; k < 20 && k < wlog.size(); k++)
            check("p2_order", 32'(wlog[k]), 32'(exp2[k]));

        // Full blocks everything; almostfull alternates with an in-flight write
        word[1] = 16'h5000;
        pack_words();
        do_reset();
        clear_hist();
        repeat (4) step(4'b0010, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            check("p3_full_gnt", 32'(ghist[k]), 32'd0);
        check("p3_full_writes", 32'(wlog.size()), 32'd0);
        clear_hist();
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        repeat (4) step(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p3_af_gnt0", 32'(ghist[0]), 32'b0010);
        check("p3_af_gnt1", 32'(ghist[1]), 32'b0000);
        check("p3_af_gnt2", 32'(ghist[2]), 32'b0010);
        check("p3_af_gnt3", 32'(ghist[3]), 32'b0000);
        check("p3_af_gnt4", 32'(ghist[4]), 32'b0010);
        check("p3_af_count", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3)
            check("p3_af_last", 32'(wlog[2]), 32'h5002);

        // Owner drops mid-burst: one bubble, then the next requester
        word[1] = 16'h6000;
        word[2] = 16'h7000;
        pack_words();
        do_reset();
        clear_hist();
        step(4'b0110, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p4_regrant", 32'(ghist[3]), 32'b0100);
        w4 = '0;
        for (int k = 0; k < 6; k++) w4 = {w4[4:0], whist[k]};
        check("p4_bubble", 32'(w4), 32'b011010);
        check("p4_count", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("p4_w0", 32'(wlog[0]), 32'h6000);
            check("p4_w1", 32'(wlog[1]), 32'h6001);
            check("p4_w2", 32'(wlog[2]), 32'h7000);
        end

        // Reset pulse during requester 3's second beat
        word[3] = 16'h8000;
        word[0] = 16'h9000;
        pack_words();
        do_reset();
        clear_hist();
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p5_rst_gnt", 32'(ghist[1]), 32'd0);
        check("p5_rst_busy", 32'(bhist[1]), 32'd0);
        check("p5_after_wr_en", 32'(whist[2]), 32'd0);
        check("p5_after_busy", 32'(bhist[2]), 32'd0);
        check("p5_after_gnt", 32'(ghist[2]), 32'b0001);
        check("p5_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("p5_w0", 32'(wlog[0]), 32'h8000);
            check("p5_w1", 32'(wlog[1]), 32'h9000);
        end

        // Random requests against a modelled FIFO with random drain
        do_reset();
        fcount = 0;
        fifo_mode = 1;
        repeat (10000) step(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        fifo_mode = 0;
        repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("p6_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
